reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_if.sv | 35 +++
 rtl/reg_scoreboard.sv | 84 ++++++++
 tb/tb_reg_scoreboard.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Issue, writeback, flush and status signals between decode/writeback and the
// register scoreboard.
interface reg_scoreboard_if #(
   parameter int NREGS = 32
);
   localparam int IDX_W = $clog2(NREGS);

   logic             iss_valid;
   logic [2:0]       iss_src_valid;
   logic [IDX_W-1:0] iss_src0;
   logic [IDX_W-1:0] iss_src1;
   logic [IDX_W-1:0] iss_src2;
   logic             iss_dst_valid;
   logic [IDX_W-1:0] iss_dst;
   logic             iss_ready;
   logic             wb_valid;
   logic [IDX_W-1:0] wb_dst;
   logic             flush;
   logic [NREGS-1:0] busy_vec;
   logic             idle;
   logic [31:0]      stall_cnt;
   logic             err_underflow;

   modport master (
      output iss_valid, iss_src_valid, iss_src0, iss_src1, iss_src2,
             iss_dst_valid, iss_dst, wb_valid, wb_dst, flush,
      input  iss_ready, busy_vec, idle, stall_cnt, err_underflow
   );

   modport slave (
      input  iss_valid, iss_src_valid, iss_src0, iss_src1, iss_src2,
             iss_dst_valid, iss_dst, wb_valid, wb_dst, flush,
      output iss_ready, busy_vec, idle, stall_cnt, err_underflow
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters gate micro-op issue
// until all read operands are clean and the destination counter has headroom.
module reg_scoreboard #(
   parameter int NREGS = 32,
   parameter int CNT_W = 2
) (
   input logic            clk,
   input logic            reset,
   reg_scoreboard_if.slave sb
);
   localparam int IDX_W = $clog2(NREGS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt     [NREGS];
   logic [CNT_W-1:0] cnt_nxt [NREGS];
   logic [NREGS-1:0] busy_c;
   logic [NREGS-1:0] busy_q;
   logic             idle_q;
   logic [31:0]      stall_q;
   logic             err_q;
   logic             src_ok;
   logic             dst_ok;
   logic             ready_c;
   logic             fire;
   logic             underflow_set;

   // Readiness only looks at start-of-cycle counts, so a same-cycle writeback
   // never unblocks an operand and an op never blocks on its own destination.
   always_comb begin
      src_ok = 1'b1;
      if (sb.iss_src_valid[0] && cnt[sb.iss_src0] != '0) src_ok = 1'b0;
      if (sb.iss_src_valid[1] && cnt[sb.iss_src1] != '0) src_ok = 1'b0;
      if (sb.iss_src_valid[2] && cnt[sb.iss_src2] != '0) src_ok = 1'b0;
      dst_ok  = !sb.iss_dst_valid || (cnt[sb.iss_dst] != CNT_MAX);
      ready_c = !reset && !sb.flush && src_ok && dst_ok;
      fire    = sb.iss_valid && ready_c;
   end

   always_comb begin
      underflow_set = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         logic inc;
         logic dec;
         inc        = fire && sb.iss_dst_valid && (sb.iss_dst == IDX_W'(r));
         dec        = sb.wb_valid && (sb.wb_dst == IDX_W'(r));
         cnt_nxt[r] = cnt[r];
         busy_c[r]  = (cnt[r] != '0);
         if (sb.flush) begin
            cnt_nxt[r] = '0;
         end else if (inc && dec) begin
            if (cnt[r] == '0) underflow_set = 1'b1;
         end else if (inc) begin
            cnt_nxt[r] = cnt[r] + CNT_W'(1);
         end else if (dec) begin
            if (cnt[r] != '0) cnt_nxt[r] = cnt[r] - CNT_W'(1);
            else              underflow_set = 1'b1;
         end
      end
   end

   // Status outputs trail the counters by one edge by construction.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
         busy_q  <= '0;
         idle_q  <= 1'b1;
         stall_q <= '0;
         err_q   <= 1'b0;
      end else begin
         for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
         busy_q <= busy_c;
         idle_q <= ~|busy_c;
         if (sb.iss_valid && !ready_c && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
         err_q <= err_q | underflow_set;
      end
   end

   assign sb.iss_ready     = ready_c;
   assign sb.busy_vec      = busy_q;
   assign sb.idle          = idle_q;
   assign sb.stall_cnt     = stall_q;
   assign sb.err_underflow = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: dependency stall, counter saturation,
// same-cycle issue/writeback, underflow, flush and reset priority.
module tb_reg_scoreboard;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   reg_scoreboard_if #(.NREGS(32)) sb ();

   reg_scoreboard #(.NREGS(32), .CNT_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic v, input logic [2:0] sv, input logic [4:0] s0,
                     input logic dv, input logic [4:0] d);
      sb.iss_valid     = v;
      sb.iss_src_valid = sv;
      sb.iss_src0      = s0;
      sb.iss_src1      = '0;
      sb.iss_src2      = '0;
      sb.iss_dst_valid = dv;
      sb.iss_dst       = d;
      #1;
   endtask

   task automatic wb(input logic v, input logic [4:0] d);
      sb.wb_valid = v;
      sb.wb_dst   = d;
      #1;
   endtask

   initial begin
      reset    = 1'b1;
      sb.flush = 1'b0;
      op(0, 3'b000, 0, 0, 0);
      wb(0, 0);
      step();
      step();
      check("rst_ready", sb.iss_ready, 0);
      check("rst_busy", sb.busy_vec, 0);
      check("rst_idle", sb.idle, 1);
      check("rst_stall", sb.stall_cnt, 0);
      check("rst_err", sb.err_underflow, 0);
      reset = 1'b0;

      // RAW dependency on r3
      op(1, 3'b000, 0, 1, 3);
      check("t1_issue_ready", sb.iss_ready, 1);
      step();
      op(1, 3'b001, 3, 0, 0);
      check("t1_raw_ready", sb.iss_ready, 0);
      step();
      check("t1_busy", sb.busy_vec, 64'h8);
      check("t1_idle", sb.idle, 0);
      check("t1_stall1", sb.stall_cnt, 1);
      step();
      check("t1_stall2", sb.stall_cnt, 2);
      wb(1, 3);
      check("t1_no_bypass", sb.iss_ready, 0);
      step();
      wb(0, 0);
      check("t1_ready_after_wb", sb.iss_ready, 1);
      check("t1_stall3", sb.stall_cnt, 3);
      step();
      op(0, 3'b000, 0, 0, 0);
      check("t1_idle_end", sb.idle, 1);

      // saturate r5 at 3
      op(1, 3'b000, 0, 1, 5);
      for (int i = 0; i < 3; i++) begin
         check("t2_ready_fill", sb.iss_ready, 1);
         step();
      end
      check("t2_full_ready", sb.iss_ready, 0);
      step();
      wb(1, 5);
      check("t2_wb_cycle_ready", sb.iss_ready, 0);
      step();
      wb(0, 0);
      check("t2_ready_after_wb", sb.iss_ready, 1);
      step();
      op(0, 3'b000, 0, 0, 0);
      check("t2_stall", sb.stall_cnt, 5);
      wb(1, 5);
      step();
      step();
      step();
      wb(0, 0);
      step();
      check("t2_idle_drained", sb.idle, 1);

      // same-cycle issue and writeback on r7
      op(1, 3'b000, 0, 1, 7);
      step();
      wb(1, 7);
      check("t3_ready", sb.iss_ready, 1);
      step();
      op(0, 3'b000, 0, 0, 0);
      wb(0, 0);
      step();
      check("t3_busy7", sb.busy_vec, 64'h80);
      wb(1, 7);
      step();
      wb(0, 0);
      step();
      check("t3_idle", sb.idle, 1);
      check("t3_err", sb.err_underflow, 0);

      // underflow on r9
      wb(1, 9);
      step();
      wb(0, 0);
      check("t4_err_set", sb.err_underflow, 1);
      check("t4_busy", sb.busy_vec, 0);
      step();
      step();
      check("t4_err_sticky", sb.err_underflow, 1);
      op(0, 3'b001, 9, 0, 0);
      check("t4_r9_zero", sb.iss_ready, 1);

      // flush with r1,r2,r4 pending
      op(1, 3'b000, 0, 1, 1);
      step();
      op(1, 3'b000, 0, 1, 2);
      step();
      op(1, 3'b000, 0, 1, 4);
      step();
      op(0, 3'b000, 0, 0, 0);
      step();
      check("t5_busy_pre", sb.busy_vec, 64'h16);
      sb.flush = 1'b1;
      step();
      sb.flush = 1'b0;
      step();
      check("t5_busy_post", sb.busy_vec, 0);
      check("t5_idle_post", sb.idle, 1);
      check("t5_stall_same", sb.stall_cnt, 5);
      sb.flush = 1'b1;
      op(1, 3'b000, 0, 1, 10);
      check("t5_flush_ready", sb.iss_ready, 0);
      step();
      sb.flush = 1'b0;
      op(0, 3'b000, 0, 0, 0);
      step();
      check("t5_not_granted", sb.busy_vec, 0);
      check("t5_flush_stall", sb.stall_cnt, 6);
      check("t5_err_kept", sb.err_underflow, 1);

      // reset mid-operation
      op(1, 3'b000, 0, 1, 20);
      step();
      op(1, 3'b001, 20, 0, 0);
      for (int i = 0; i < 4; i++) step();
      check("t6_stall10", sb.stall_cnt, 10);
      check("t6_busy20", sb.busy_vec, 64'h100000);
      reset = 1'b1;
      #1;
      check("t6_rst_ready", sb.iss_ready, 0);
      step();
      check("t6_stall0", sb.stall_cnt, 0);
      check("t6_busy0", sb.busy_vec, 0);
      check("t6_idle", sb.idle, 1);
      check("t6_err0", sb.err_underflow, 0);
      check("t6_rst_ready_held", sb.iss_ready, 0);
      step();
      check("t6_stall_held", sb.stall_cnt, 0);
      reset = 1'b0;
      #1;
      check("t6_r20_cleared", sb.iss_ready, 1);
      op(0, 3'b000, 0, 0, 0);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
